sat_mode_sequencer: RTL and testbench
=====================================

SAT_MODE_SEQUENCER -- requirements
Module: sat_mode_sequencer

Interface
REQ-001 SHALL provide parameter QUIET_CYCLES, default 4: consecutive idle-stream cycles required before a mode switch; legal range 1..254.
REQ-002 SHALL provide parameter SETTLE_CYCLES, default 2: cycles output valid is blanked after a switch; legal range 1..255.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 255: maximum DRAIN cycles before a forced switch; legal range QUIET_CYCLES+1..255.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL provide port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL provide port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL provide port mode_req, input, 2 bits: requested saturator mode (0 flat, 1 low pass, 2 band pass, 3 high pass).
REQ-008 SHALL provide port mode_req_valid, input, 1 bit: request strobe.
REQ-009 SHALL provide port mode_req_ready, output, 1 bit: request can be accepted.
REQ-010 SHALL provide port ast_sink_valid, input, 1 bit: upstream FIR stream valid, used for idle detection.
REQ-011 SHALL provide port sat_valid_in, input, 1 bit: valid from the selected saturator output.
REQ-012 SHALL provide port sel, output, 2 bits: registered mode select driven to the saturator mux.
REQ-013 SHALL provide port ast_source_valid, output, 1 bit: gated output valid.
REQ-014 SHALL provide port mode_ack, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL provide port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 SHALL provide port forced, output, 1 bit: the last switch was taken by timeout.

Function
REQ-017 SHALL implement the FSM states IDLE, DRAIN, SWITCH, SETTLE.
REQ-018 SHALL drive mode_req_ready = 1 only in IDLE; a request is accepted on a rising edge where mode_req_valid and mode_req_ready are both 1, and mode_req is captured into a pending register.
REQ-019 SHALL, on acceptance with mode_req equal to sel, stay in IDLE, leave sel unchanged, pulse mode_ack on the next cycle, and clear forced.
REQ-020 SHALL, on acceptance with mode_req different from sel, enter DRAIN on the next cycle with the quiet and timeout counters (8 bits each) cleared and forced cleared.
REQ-021 SHALL, in DRAIN, increment the quiet counter each cycle ast_sink_valid=0 and clear it each cycle ast_sink_valid=1; the timeout counter increments every DRAIN cycle.
REQ-022 SHALL leave DRAIN for SWITCH when the quiet counter reaches QUIET_CYCLES (forced stays 0), or when the timeout counter reaches TIMEOUT_CYCLES (forced set to 1); if both occur in the same cycle, the quiet exit wins and forced stays 0.
REQ-023 SHALL last exactly 1 cycle in SWITCH, load sel from the pending register on the SWITCH->SETTLE edge, and clear the settle counter.
REQ-024 SHALL remain in SETTLE for SETTLE_CYCLES cycles, then return to IDLE with mode_ack=1 for exactly the first IDLE cycle.
REQ-025 SHALL drive ast_source_valid = sat_valid_in AND NOT blank, combinationally, where blank = (state is SWITCH or SETTLE).
REQ-026 SHALL ignore mode_req_valid outside IDLE; the requester must hold the request until it is accepted.
REQ-027 SHALL keep sel stable except on the SWITCH->SETTLE edge.

Reset
REQ-028 SHALL, while reset=1 (asynchronously, including mid-operation), force state=IDLE, sel=0, all counters=0, pending=0, mode_ack=0, forced=0, busy=0; mode_req_ready=1 once reset deasserts.
REQ-029 SHALL discard any in-flight request on reset; no mode_ack is issued for it.

Verification
REQ-030 SHALL verify same-mode request: after reset, mode_req=0 accepted at cycle T -> no busy, sel=0 throughout, mode_ack=1 at T+1 only.
REQ-031 SHALL verify quiet switch with defaults: sel=0, ast_sink_valid=0, mode_req=2 accepted at T -> DRAIN T+1..T+4, SWITCH T+5, sel=2 from T+6, blank T+5..T+7, mode_ack at T+8.
REQ-032 SHALL verify quiet reset: in DRAIN, ast_sink_valid pattern 0,0,0,1,0,0,0,0 -> SWITCH entered only after 4 consecutive zeros following the 1; forced=0.
REQ-033 SHALL verify timeout: ast_sink_valid held 1, mode_req=3 -> SWITCH after 255 DRAIN cycles, forced=1, sel=3, mode_ack pulse.
REQ-034 SHALL verify blanking: sat_valid_in held 1 throughout a switch -> ast_source_valid=0 exactly during SWITCH+SETTLE (3 cycles), otherwise 1.
REQ-035 SHALL verify reset mid-SETTLE after a request for mode 1 -> sel=0, busy=0, no mode_ack, and a new request is accepted on the first post-reset cycle.

Source files
------------

// File: rtl/sat_mode_sequencer.sv
// Mode-switch sequencer for the saturator mux: waits for the upstream stream to
// go quiet (or times out), swaps the mux select, and blanks output valid while it settles.
module sat_mode_sequencer #(
  parameter int QUIET_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode_req,
  input  logic       mode_req_valid,
  output logic       mode_req_ready,
  input  logic       ast_sink_valid,
  input  logic       sat_valid_in,
  output logic [1:0] sel,
  output logic       ast_source_valid,
  output logic       mode_ack,
  output logic       busy,
  output logic       forced
);

  typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, SETTLE} state_t;

  localparam logic [8:0] QUIET_LIM   = 9'(QUIET_CYCLES);
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] pending;
  logic [7:0] quiet_cnt;
  logic [7:0] timeout_cnt;
  logic [7:0] settle_cnt;
  logic [8:0] quiet_next;
  logic [8:0] timeout_next;
  logic       blank;

  // Counter look-ahead is one bit wider so a limit of 255 compares cleanly.
  always_comb begin
    quiet_next   = ast_sink_valid ? 9'd0 : ({1'b0, quiet_cnt} + 9'd1);
    timeout_next = {1'b0, timeout_cnt} + 9'd1;
  end

  assign mode_req_ready   = (state == IDLE);
  assign busy             = (state != IDLE);
  assign blank            = (state == SWITCH) || (state == SETTLE);
  assign ast_source_valid = sat_valid_in & ~blank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= 2'd0;
      pending     <= 2'd0;
      quiet_cnt   <= 8'd0;
      timeout_cnt <= 8'd0;
      settle_cnt  <= 8'd0;
      mode_ack    <= 1'b0;
      forced      <= 1'b0;
    end else begin
      mode_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (mode_req_valid && mode_req_ready) begin
            pending <= mode_req;
            forced  <= 1'b0;
            if (mode_req == sel) begin
              mode_ack <= 1'b1;
            end else begin
              state       <= DRAIN;
              quiet_cnt   <= 8'd0;
              timeout_cnt <= 8'd0;
            end
          end
        end
        DRAIN: begin
          quiet_cnt   <= quiet_next[7:0];
          timeout_cnt <= timeout_next[7:0];
          // Quiet exit takes priority so a coincident timeout is not reported as forced.
          if (quiet_next == QUIET_LIM) begin
            state <= SWITCH;
          end else if (timeout_next == TIMEOUT_LIM) begin
            state  <= SWITCH;
            forced <= 1'b1;
          end
        end
        SWITCH: begin
          sel        <= pending;
          settle_cnt <= 8'd0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state    <= IDLE;
            mode_ack <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sat_mode_sequencer.sv
// Scenario bench for sat_mode_sequencer with default parameters; expected
// mode_ack events are queued when a request is driven and matched when the pulse appears.
module tb_sat_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode_req = 2'd0;
  logic       mode_req_valid = 1'b0;
  logic       ast_sink_valid = 1'b0;
  logic       sat_valid_in = 1'b0;
  logic       mode_req_ready;
  logic [1:0] sel;
  logic       ast_source_valid;
  logic       mode_ack;
  logic       busy;
  logic       forced;

  typedef struct {
    logic [1:0] sel;
    logic       forced;
    int         due;
  } ack_t;

  ack_t       ack_q[$];
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;
  logic [1:0] model_sel = 2'd0;

  sat_mode_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .mode_req        (mode_req),
    .mode_req_valid  (mode_req_valid),
    .mode_req_ready  (mode_req_ready),
    .ast_sink_valid  (ast_sink_valid),
    .sat_valid_in    (sat_valid_in),
    .sel             (sel),
    .ast_source_valid(ast_source_valid),
    .mode_ack        (mode_ack),
    .busy            (busy),
    .forced          (forced)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #2;
    reset = 1'b1;
    mode_req = 2'd2;
    mode_req_valid = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (sel !== 2'd0 || busy !== 1'b0 || mode_ack !== 1'b0 || forced !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: got sel=%0d busy=%b ack=%b forced=%b, expected 0 0 0 0",
               sel, busy, mode_ack, forced);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mode_req_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (mode_req_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: got ready=%b busy=%b, expected 1 0", mode_req_ready, busy);
    end
  endtask

  task automatic test_same_mode(input logic [1:0] mode);
    int   t;
    ack_t e;
    @(posedge clk); #1;
    mode_req = mode;
    mode_req_valid = 1'b1;
    @(negedge clk);
    t = cyc;
    compared++;
    if (mode_req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL same_ready: got %b expected 1", mode_req_ready);
    end
    ack_q.push_back('{sel: mode, forced: 1'b0, due: t + 1});
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      mode_req_valid = 1'b0;
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || sel !== mode || forced !== 1'b0) begin
        mismatched++;
        $display("FAIL same_state k=%0d: got busy=%b sel=%0d forced=%b, expected 0 %0d 0",
                 k, busy, sel, forced, mode);
      end
      if (mode_ack) begin
        compared++;
        if (ack_q.size() == 0) begin
          mismatched++;
          $display("FAIL same_ack_unexpected: got ack at cycle %0d, expected none", cyc);
        end else begin
          e = ack_q.pop_front();
          if (cyc !== e.due || sel !== e.sel || forced !== e.forced) begin
            mismatched++;
            $display("FAIL same_ack: got cycle=%0d sel=%0d forced=%b, expected %0d %0d %b",
                     cyc, sel, forced, e.due, e.sel, e.forced);
          end
        end
      end
    end
    compared++;
    if (ack_q.size() != 0) begin
      mismatched++;
      $display("FAIL same_ack_missing: got %0d pending acks, expected 0", ack_q.size());
    end
    ack_q.delete();
  endtask

  // sink_mode: 0 = stream idle, 1 = idle with one valid beat in the 4th DRAIN cycle, 2 = stream busy.
  task automatic test_mode_switch(input string name, input logic [1:0] new_mode,
                                  input int sink_mode, input int drain, input logic exp_forced);
    int         t;
    ack_t       e;
    logic [7:0] pat;
    logic [1:0] old_sel;
    logic       eb, ek;
    logic [1:0] es;
    logic       ef;
    pat = 8'b0000_1000;
    old_sel = model_sel;
    @(posedge clk); #1;
    mode_req = new_mode;
    mode_req_valid = 1'b1;
    sat_valid_in = 1'b1;
    ast_sink_valid = (sink_mode == 2);
    @(negedge clk);
    t = cyc;
    compared++;
    if (mode_req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s ready: got %b expected 1", name, mode_req_ready);
    end
    ack_q.push_back('{sel: new_mode, forced: exp_forced, due: t + drain + 4});
    for (int k = 1; k <= drain + 6; k++) begin
      @(posedge clk); #1;
      // A different request held while busy must not be picked up.
      if (k <= drain + 2) begin
        mode_req = new_mode ^ 2'd1;
        mode_req_valid = 1'b1;
      end else begin
        mode_req_valid = 1'b0;
      end
      if (sink_mode == 0) ast_sink_valid = 1'b0;
      else if (sink_mode == 1) ast_sink_valid = (k <= 8) ? pat[k-1] : 1'b0;
      else ast_sink_valid = 1'b1;
      @(negedge clk);
      eb = (k <= drain + 3);
      ek = (k >= drain + 1) && (k <= drain + 3);
      es = (k >= drain + 2) ? new_mode : old_sel;
      ef = (k >= drain + 1) ? exp_forced : 1'b0;
      compared++;
      if (busy !== eb || mode_req_ready !== !eb) begin
        mismatched++;
        $display("FAIL %s busy k=%0d: got busy=%b ready=%b, expected %b %b",
                 name, k, busy, mode_req_ready, eb, !eb);
      end
      compared++;
      if (ast_source_valid !== !ek) begin
        mismatched++;
        $display("FAIL %s blank k=%0d: got src_valid=%b expected %b", name, k, ast_source_valid, !ek);
      end
      compared++;
      if (sel !== es || forced !== ef) begin
        mismatched++;
        $display("FAIL %s sel k=%0d: got sel=%0d forced=%b, expected %0d %b",
                 name, k, sel, forced, es, ef);
      end
      if (mode_ack) begin
        compared++;
        if (ack_q.size() == 0) begin
          mismatched++;
          $display("FAIL %s ack_unexpected: got ack at cycle %0d, expected none", name, cyc);
        end else begin
          e = ack_q.pop_front();
          if (cyc !== e.due || sel !== e.sel || forced !== e.forced) begin
            mismatched++;
            $display("FAIL %s ack: got cycle=%0d sel=%0d forced=%b, expected %0d %0d %b",
                     name, cyc, sel, forced, e.due, e.sel, e.forced);
          end
        end
      end
    end
    compared++;
    if (ack_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s ack_missing: got %0d pending acks, expected 0", name, ack_q.size());
    end
    ack_q.delete();
    model_sel = new_mode;
  endtask

  task automatic test_reset_mid_settle();
    int   t;
    ack_t e;
    @(posedge clk); #1;
    mode_req = 2'd1;
    mode_req_valid = 1'b1;
    ast_sink_valid = 1'b0;
    sat_valid_in = 1'b1;
    @(negedge clk);
    t = cyc;
    ack_q.push_back('{sel: 2'd1, forced: 1'b0, due: t + 8});
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      mode_req_valid = 1'b0;
      @(negedge clk);
    end
    compared++;
    if (busy !== 1'b1 || sel !== 2'd1 || ast_source_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rms_in_settle: got busy=%b sel=%0d src_valid=%b, expected 1 1 0",
               busy, sel, ast_source_valid);
    end
    // Reset lands mid-cycle; the in-flight request must vanish without an ack.
    reset = 1'b1;
    ack_q.delete();
    #1;
    compared++;
    if (sel !== 2'd0 || busy !== 1'b0 || mode_ack !== 1'b0 || forced !== 1'b0 ||
        ast_source_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rms_async: got sel=%0d busy=%b ack=%b forced=%b src_valid=%b, expected 0 0 0 0 1",
               sel, busy, mode_ack, forced, ast_source_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_sel = 2'd0;
    mode_req = 2'd2;
    mode_req_valid = 1'b1;
    @(negedge clk);
    t = cyc;
    compared++;
    if (mode_req_ready !== 1'b1 || mode_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL rms_first_cycle: got ready=%b ack=%b, expected 1 0", mode_req_ready, mode_ack);
    end
    ack_q.push_back('{sel: 2'd2, forced: 1'b0, due: t + 8});
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      mode_req_valid = 1'b0;
      @(negedge clk);
      compared++;
      if (busy !== (k <= 7) || sel !== ((k >= 6) ? 2'd2 : 2'd0)) begin
        mismatched++;
        $display("FAIL rms_after k=%0d: got busy=%b sel=%0d, expected %b %0d",
                 k, busy, sel, (k <= 7), ((k >= 6) ? 2'd2 : 2'd0));
      end
      if (mode_ack) begin
        compared++;
        if (ack_q.size() == 0) begin
          mismatched++;
          $display("FAIL rms_ack_unexpected: got ack at cycle %0d, expected none", cyc);
        end else begin
          e = ack_q.pop_front();
          if (cyc !== e.due || sel !== e.sel || forced !== e.forced) begin
            mismatched++;
            $display("FAIL rms_ack: got cycle=%0d sel=%0d forced=%b, expected %0d %0d %b",
                     cyc, sel, forced, e.due, e.sel, e.forced);
          end
        end
      end
    end
    compared++;
    if (ack_q.size() != 0) begin
      mismatched++;
      $display("FAIL rms_ack_missing: got %0d pending acks, expected 0", ack_q.size());
    end
    ack_q.delete();
    model_sel = 2'd2;
  endtask

  initial begin
    test_reset();
    test_same_mode(2'd0);
    test_mode_switch("quiet", 2'd2, 0, 4, 1'b0);
    test_mode_switch("quiet_restart", 2'd1, 1, 8, 1'b0);
    test_mode_switch("timeout", 2'd3, 2, 255, 1'b1);
    test_same_mode(2'd3);
    test_reset_mid_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
